// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
// Module   : iter_shifter
// Purpose  : Multi-cycle SLL/SRL/SRA/ROL unit that resolves STEP shift bits
//            per cycle, with valid/ready handshakes on both sides.
// Revision : 1.0  initial release
// ============================================================================
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SHW  = $clog2(WIDTH),
    localparam int NST  = (SHW + STEP - 1) / STEP
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);
    localparam int            KW        = (NST > 1) ? $clog2(NST) : 1;
    localparam logic [KW-1:0] c_LAST_K  = KW'(NST - 1);
    localparam logic [1:0]    c_OP_SLL  = 2'b00;
    localparam logic [1:0]    c_OP_SRL  = 2'b01;
    localparam logic [1:0]    c_OP_SRA  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_val;
    logic [WIDTH-1:0]     w_stage;
    logic [SHW-1:0]       r_shamt;
    logic [SHW-1:0]       w_amt;
    logic [1:0]           r_op;
    logic [KW-1:0]        r_k;
    logic                 r_ovf;
    logic                 w_ovf_hit;
    logic [2*WIDTH-1:0]   w_rot;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)          w_next = S_SHIFT;
            S_SHIFT: if (r_k == c_LAST_K)   w_next = S_DONE;
            S_DONE:  if (out_ready)         w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    // Stage k keeps only its own slice of the shift amount, already weighted.
    always_comb begin
        w_amt = '0;
        for (int i = 0; i < SHW; i++) begin
            if ((i / STEP) == int'(r_k)) begin
                w_amt[i] = r_shamt[i];
            end
        end
    end

    // Adjacent-bit XOR over the top a bits flags any disagreement in the top a+1 bits.
    always_comb begin
        w_rot     = {r_val, r_val} << w_amt;
        w_ovf_hit = |((r_val ^ (r_val << 1)) & ~({WIDTH{1'b1}} >> w_amt));
        case (r_op)
            c_OP_SLL: w_stage = r_val << w_amt;
            c_OP_SRL: w_stage = r_val >> w_amt;
            c_OP_SRA: w_stage = $signed(r_val) >>> w_amt;
            default:  w_stage = w_rot[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_val   <= '0;
            r_shamt <= '0;
            r_op    <= '0;
            r_k     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_val   <= in_data;
                        r_shamt <= in_shamt;
                        r_op    <= in_op;
                        r_k     <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_val <= w_stage;
                    r_k   <= r_k + 1'b1;
                    if (r_op == c_OP_SLL && w_ovf_hit) begin
                        r_ovf <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_val;
    assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_iter_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_iter_shifter
// Purpose  : Self-checking bench for iter_shifter across six WIDTH/STEP configs.
// Revision : 1.0  initial release
// ============================================================================
module tb_iter_shifter;
    logic        clock = 1'b0;
    logic        rst_n;
    logic [5:0]  vld;
    logic [5:0]  ordy;
    logic [63:0] din [6];
    logic [5:0]  sh  [6];
    logic [1:0]  op  [6];
    wire  [5:0]  irdy;
    wire  [5:0]  ovld;
    wire  [5:0]  ovfw;
    wire  [31:0] q0, q1, q2, q3;
    wire  [7:0]  q4;
    wire  [63:0] q5;

    int checks = 0;
    int errors = 0;
    int cw [6];
    int cn [6];

    always #5 clock = ~clock;

    iter_shifter #(.WIDTH(32), .STEP(1)) u0 (.clock(clock), .reset_n(rst_n), .in_valid(vld[0]), .in_ready(irdy[0]),
        .in_data(din[0][31:0]), .in_shamt(sh[0][4:0]), .in_op(op[0]), .out_valid(ovld[0]), .out_ready(ordy[0]),
        .out_data(q0), .out_ovf(ovfw[0]));
    iter_shifter #(.WIDTH(32), .STEP(2)) u1 (.clock(clock), .reset_n(rst_n), .in_valid(vld[1]), .in_ready(irdy[1]),
        .in_data(din[1][31:0]), .in_shamt(sh[1][4:0]), .in_op(op[1]), .out_valid(ovld[1]), .out_ready(ordy[1]),
        .out_data(q1), .out_ovf(ovfw[1]));
    iter_shifter #(.WIDTH(32), .STEP(3)) u2 (.clock(clock), .reset_n(rst_n), .in_valid(vld[2]), .in_ready(irdy[2]),
        .in_data(din[2][31:0]), .in_shamt(sh[2][4:0]), .in_op(op[2]), .out_valid(ovld[2]), .out_ready(ordy[2]),
        .out_data(q2), .out_ovf(ovfw[2]));
    iter_shifter #(.WIDTH(32), .STEP(5)) u3 (.clock(clock), .reset_n(rst_n), .in_valid(vld[3]), .in_ready(irdy[3]),
        .in_data(din[3][31:0]), .in_shamt(sh[3][4:0]), .in_op(op[3]), .out_valid(ovld[3]), .out_ready(ordy[3]),
        .out_data(q3), .out_ovf(ovfw[3]));
    iter_shifter #(.WIDTH(8), .STEP(1)) u4 (.clock(clock), .reset_n(rst_n), .in_valid(vld[4]), .in_ready(irdy[4]),
        .in_data(din[4][7:0]), .in_shamt(sh[4][2:0]), .in_op(op[4]), .out_valid(ovld[4]), .out_ready(ordy[4]),
        .out_data(q4), .out_ovf(ovfw[4]));
    iter_shifter #(.WIDTH(64), .STEP(1)) u5 (.clock(clock), .reset_n(rst_n), .in_valid(vld[5]), .in_ready(irdy[5]),
        .in_data(din[5]), .in_shamt(sh[5]), .in_op(op[5]), .out_valid(ovld[5]), .out_ready(ordy[5]),
        .out_data(q5), .out_ovf(ovfw[5]));

    function automatic logic [63:0] get_dout(input int c);
        case (c)
            0:       return 64'(q0);
            1:       return 64'(q1);
            2:       return 64'(q2);
            3:       return 64'(q3);
            4:       return 64'(q4);
            default: return q5;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole shift computed at once from the mode definitions.
    function automatic void model(input int w, input logic [1:0] o, input logic [63:0] a_in, input int s,
                                  output logic [63:0] r, output logic ov);
        logic [63:0] m;
        logic [63:0] a;
        logic        msb;
        m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a   = a_in & m;
        msb = a[w-1];
        ov  = 1'b0;
        case (o)
            2'd0: begin
                r = (a << s) & m;
                for (int i = w - 1 - s; i < w; i++) if (a[i] != msb) ov = 1'b1;
            end
            2'd1:    r = a >> s;
            2'd2:    r = (a >> s) | (msb ? (m & ~(m >> s)) : 64'd0);
            default: r = (s == 0) ? a : (((a << s) | (a >> (w - s))) & m);
        endcase
    endfunction

    // One transaction; called and returning at 1ns after a rising edge.
    task automatic do_op(input int c, input logic [1:0] o, input logic [63:0] d, input int s, input int hold,
                         output logic [63:0] r, output logic f, output int lat);
        int   n;
        logic stable;
        n = 0;
        while (!irdy[c] && n < 100) begin @(posedge clock); #1; n++; end
        chk("ready_before_accept", 64'(irdy[c]), 64'd1);
        vld[c] = 1'b1; din[c] = d; sh[c] = 6'(s); op[c] = o;
        @(posedge clock); #1;
        vld[c] = 1'b0; din[c] = {$urandom, $urandom}; sh[c] = 6'($urandom); op[c] = 2'($urandom);
        lat = 0;
        while (!ovld[c] && lat < 100) begin @(posedge clock); #1; lat++; end
        r = get_dout(c);
        f = ovfw[c];
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clock); #1;
                if (!ovld[c] || irdy[c] || get_dout(c) != r || ovfw[c] != f) stable = 1'b0;
            end
            chk("hold_stable", 64'(stable), 64'd1);
        end
        ordy[c] = 1'b1;
        @(posedge clock); #1;
        ordy[c] = 1'b0;
        chk("released_valid_ready", {62'd0, ovld[c], irdy[c]}, 64'd1);
    endtask

    task automatic run_random(input int c, input int n);
        logic [63:0] d, r, er;
        logic        f, ef;
        logic [1:0]  o;
        int          s, lat, hold;
        for (int k = 0; k < n; k++) begin
            d = {$urandom, $urandom};
            if (cw[c] < 64) d = d & ((64'd1 << cw[c]) - 64'd1);
            o    = 2'($urandom);
            s    = int'($urandom_range(cw[c] - 1, 0));
            hold = ($urandom_range(9, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            model(cw[c], o, d, s, er, ef);
            do_op(c, o, d, s, hold, r, f, lat);
            chk("rand_data", r, er);
            chk("rand_ovf", 64'(f), 64'(ef));
            chk("rand_latency", 64'(lat), 64'(cn[c]));
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        int          s;
        logic [31:0] d;
        logic [31:0] exp;
        logic        eovf;
        int          hold;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic        f, seen, bad;
        int          lat, j;

        cw = '{32, 32, 32, 32, 8, 64};
        cn = '{5, 3, 2, 1, 3, 6};
        tbl[0] = '{2'd0, 1,  32'hAFAF0800, 32'h5F5E1000, 1'b1, 0};
        tbl[1] = '{2'd1, 4,  32'hAFAF0800, 32'h0AFAF080, 1'b0, 0};
        tbl[2] = '{2'd2, 4,  32'hAFAF0800, 32'hFAFAF080, 1'b0, 0};
        tbl[3] = '{2'd3, 4,  32'hAFAF0800, 32'hFAF0800A, 1'b0, 7};
        tbl[4] = '{2'd2, 31, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0};
        tbl[5] = '{2'd0, 31, 32'h00000001, 32'h80000000, 1'b1, 0};
        tbl[6] = '{2'd0, 0,  32'hAFAF0800, 32'hAFAF0800, 1'b0, 0};
        tbl[7] = '{2'd1, 0,  32'hAFAF0800, 32'hAFAF0800, 1'b0, 0};
        tbl[8] = '{2'd2, 0,  32'hAFAF0800, 32'hAFAF0800, 1'b0, 0};
        tbl[9] = '{2'd3, 0,  32'hAFAF0800, 32'hAFAF0800, 1'b0, 2};

        rst_n = 1'b0; vld = '0; ordy = '0;
        for (int c = 0; c < 6; c++) begin din[c] = '0; sh[c] = '0; op[c] = '0; end
        repeat (3) @(posedge clock);
        #1;
        for (int c = 0; c < 6; c++) begin
            chk("reset_flags", {61'd0, irdy[c], ovld[c], ovfw[c]}, 64'b100);
            chk("reset_data", get_dout(c), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 10; i++) begin
            do_op(0, tbl[i].op, 64'(tbl[i].d), tbl[i].s, tbl[i].hold, r, f, lat);
            chk("vec_data", r, 64'(tbl[i].exp));
            chk("vec_ovf", 64'(f), 64'(tbl[i].eovf));
            chk("vec_latency", 64'(lat), 64'd5);
        end

        // Back-to-back: in_valid held high, out_ready always high.
        vld[0] = 1'b1; din[0] = 64'hAFAF0800; sh[0] = 6'd4; op[0] = 2'd3; ordy[0] = 1'b1;
        @(posedge clock); #1;
        din[0] = 64'h12345678; sh[0] = 6'd0; op[0] = 2'd0;
        j = 0; seen = 1'b0;
        while (!irdy[0] && j < 50) begin
            @(posedge clock); #1; j++;
            if (ovld[0]) begin
                chk("b2b_first_data", get_dout(0), 64'hFAF0800A);
                seen = 1'b1;
            end
        end
        chk("b2b_first_seen", 64'(seen), 64'd1);
        chk("b2b_ready_cycle", 64'(j), 64'd6);
        @(posedge clock); #1;
        vld[0] = 1'b0;
        lat = 0;
        while (!ovld[0] && lat < 50) begin @(posedge clock); #1; lat++; end
        chk("b2b_second_latency", 64'(lat), 64'd5);
        chk("b2b_second_data", get_dout(0), 64'h12345678);
        @(posedge clock); #1;
        ordy[0] = 1'b0;

        // Reset at the edge that would perform shift stage 2.
        vld[0] = 1'b1; din[0] = 64'hAFAF0800; sh[0] = 6'd1; op[0] = 2'd0;
        @(posedge clock); #1;
        vld[0] = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        rst_n = 1'b0;
        @(posedge clock); #1;
        chk("midreset_flags", {61'd0, irdy[0], ovld[0], ovfw[0]}, 64'b100);
        chk("midreset_data", get_dout(0), 64'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (12) begin @(posedge clock); #1; if (ovld[0]) bad = 1'b1; end
        chk("midreset_no_stale", 64'(bad), 64'd0);

        for (int c = 0; c < 6; c++) run_random(c, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
